// File: rtl/alu_sequencer_if.sv
// Command/response bundle for alu_sequencer: request fields from the master,
// status and results back from the sequencer.
interface alu_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] result_hi;
    logic [3:0]  sreg;
    logic        err;

    modport master (
        output start, op, a, b,
        input  busy, done, result, result_hi, sreg, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, result_hi, sreg, err
    );
endinterface

// File: rtl/alu_sequencer.sv
// 16-bit multi-cycle ALU sequencer with a shared combinational ALU.
// Define ALU_SEQ_MUL_EN to build in the shift-add unsigned multiplier (op 111).
module alu_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  alu_op,
    output logic [15:0] y,
    output logic        carry,
    output logic        ovf
);
    logic [16:0] sum;
    logic [16:0] diff;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} + {1'b0, ~b} + 17'd1;
        y     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (alu_op)
            3'b000: y = a & b;
            3'b001: y = a | b;
            3'b010: begin
                y     = sum[15:0];
                carry = sum[16];
                ovf   = (a[15] == b[15]) && (sum[15] != a[15]);
            end
            3'b110: begin
                y     = diff[15:0];
                carry = diff[16];
                ovf   = (a[15] != b[15]) && (diff[15] != a[15]);
            end
            default: ;
        endcase
    end
endmodule

module alu_sequencer (
    input logic            clk,
    input logic            rst_n,
    alu_sequencer_if.slave bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [1:0] StMul  = 2'd2;
`endif
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  sreg_q, sreg_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_op;
    logic        alu_c, alu_v;
    logic        legal;
`ifdef ALU_SEQ_MUL_EN
    logic [15:0] result_hi_q, result_hi_d;
    logic [15:0] p_hi_q, p_hi_d;
    logic [15:0] p_lo_q, p_lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] mul_sum, mul_hi_n, mul_lo_n;
    logic        mul_c;
`endif

    alu_16bit u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .alu_op (alu_op),
        .y      (alu_y),
        .carry  (alu_c),
        .ovf    (alu_v)
    );

    // Multiply iterations borrow the ALU as an adder on the upper partial word.
    always_comb begin
        alu_a  = a_q;
        alu_b  = b_q;
        alu_op = op_q;
`ifdef ALU_SEQ_MUL_EN
        if (state_q == StMul) begin
            alu_a  = p_hi_q;
            alu_b  = a_q;
            alu_op = 3'b010;
        end
`endif
    end

    assign legal = (op_q == 3'b000) || (op_q == 3'b001) || (op_q == 3'b010) ||
                   (op_q == 3'b110);

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        result_d = result_q;
        sreg_d   = sreg_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
`ifdef ALU_SEQ_MUL_EN
        result_hi_d = result_hi_q;
        p_hi_d      = p_hi_q;
        p_lo_d      = p_lo_q;
        cnt_d       = cnt_q;
        mul_c       = p_lo_q[0] & alu_c;
        mul_sum     = p_lo_q[0] ? alu_y : p_hi_q;
        mul_hi_n    = {mul_c, mul_sum[15:1]};
        mul_lo_n    = {mul_sum[0], p_lo_q[15:1]};
`endif
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    busy_d  = 1'b1;
                    state_d = StExec;
`ifdef ALU_SEQ_MUL_EN
                    if (bus.op == 3'b111) begin
                        state_d = StMul;
                        cnt_d   = '0;
                        p_hi_d  = '0;
                        p_lo_d  = bus.b;
                    end
`endif
                end
            end
            StExec: begin
                state_d = StDone;
                done_d  = 1'b1;
`ifdef ALU_SEQ_MUL_EN
                result_hi_d = '0;
`endif
                if (legal) begin
                    result_d = alu_y;
                    err_d    = 1'b0;
                    sreg_d   = {alu_v, alu_c, alu_y[15], alu_y == 16'h0000};
                end else begin
                    result_d = '0;
                    err_d    = 1'b1;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            StMul: begin
                p_hi_d = mul_hi_n;
                p_lo_d = mul_lo_n;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d     = StDone;
                    done_d      = 1'b1;
                    err_d       = 1'b0;
                    result_d    = mul_lo_n;
                    result_hi_d = mul_hi_n;
                    sreg_d      = {mul_hi_n != 16'h0000, 1'b0, mul_hi_n[15],
                                   {mul_hi_n, mul_lo_n} == 32'h0};
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            sreg_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
`ifdef ALU_SEQ_MUL_EN
            result_hi_q <= '0;
            p_hi_q      <= '0;
            p_lo_q      <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            sreg_q   <= sreg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
`ifdef ALU_SEQ_MUL_EN
            result_hi_q <= result_hi_d;
            p_hi_q      <= p_hi_d;
            p_lo_q      <= p_lo_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
    assign bus.sreg   = sreg_q;
`ifdef ALU_SEQ_MUL_EN
    assign bus.result_hi = result_hi_q;
`else
    assign bus.result_hi = 16'h0000;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; MUL scenarios run only when
// ALU_SEQ_MUL_EN is defined, otherwise op 111 is checked as illegal.
module tb_alu_sequencer;
    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request cycle; returns just after the acceptance edge.
    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cycles++;
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.op    = OpAdd;
        bus.a     = 16'h0001;
        bus.b     = 16'h0001;
        tick();
        tick();
        tests++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: busy/done/err got %b want 000",
                     {bus.busy, bus.done, bus.err});
        end
        tests++;
        if ({bus.result, bus.result_hi, bus.sreg} !== 36'h0) begin
            fails++;
            $display("FAIL reset_data: result %h result_hi %h sreg %b want all 0",
                     bus.result, bus.result_hi, bus.sreg);
        end
        rst_n = 1'b1;
        tick();
        bus.start = 1'b0;
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL first_start: busy got %b want 1", bus.busy);
        end
        tick();
        tests++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0002) begin
            fails++;
            $display("FAIL first_result: done %b result %h want 1 0002", bus.done, bus.result);
        end
        tick();
    endtask

    task automatic test_add();
        int cycles;
        bit ok;
        send(OpAdd, 16'h7FFF, 16'h0001);
        tests++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL add_accept: busy %b done %b want 1 0", bus.busy, bus.done);
        end
        wait_done(cycles, ok);
        tests++;
        if (!ok || cycles != 1) begin
            fails++;
            $display("FAIL add_latency: got %0d cycles (seen %0d) want 1", cycles, ok);
        end
        tests++;
        if (bus.result !== 16'h8000 || bus.sreg !== 4'b1010 || bus.err !== 1'b0 ||
            bus.result_hi !== 16'h0000) begin
            fails++;
            $display("FAIL add_ovf: result %h sreg %b err %b hi %h want 8000 1010 0 0000",
                     bus.result, bus.sreg, bus.err, bus.result_hi);
        end
        tick();
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 16'h8000) begin
            fails++;
            $display("FAIL add_after: done %b busy %b result %h want 0 0 8000",
                     bus.done, bus.busy, bus.result);
        end
        send(OpAdd, 16'hFFFF, 16'h0001);
        wait_done(cycles, ok);
        tests++;
        if (!ok || bus.result !== 16'h0000 || bus.sreg !== 4'b0101) begin
            fails++;
            $display("FAIL add_carry: result %h sreg %b want 0000 0101", bus.result, bus.sreg);
        end
        tick();
    endtask

    task automatic test_logic();
        logic [2:0]  ops  [3];
        logic [15:0] av   [3];
        logic [15:0] bv   [3];
        logic [15:0] expr [3];
        logic [3:0]  exps [3];
        int cycles;
        bit ok;
        ops[0] = OpAnd; av[0] = 16'hF0F0; bv[0] = 16'h0FF0; expr[0] = 16'h00F0; exps[0] = 4'b0000;
        ops[1] = OpOr;  av[1] = 16'h8000; bv[1] = 16'h0001; expr[1] = 16'h8001; exps[1] = 4'b0010;
        ops[2] = OpAnd; av[2] = 16'h00FF; bv[2] = 16'hFF00; expr[2] = 16'h0000; exps[2] = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            send(ops[i], av[i], bv[i]);
            wait_done(cycles, ok);
            tests++;
            if (!ok || bus.result !== expr[i] || bus.sreg !== exps[i] || bus.err !== 1'b0) begin
                fails++;
                $display("FAIL logic_%0d: result %h sreg %b err %b want %h %b 0",
                         i, bus.result, bus.sreg, bus.err, expr[i], exps[i]);
            end
            tick();
        end
    endtask

    task automatic test_sub();
        int cycles;
        bit ok;
        send(OpSub, 16'h0005, 16'h0005);
        wait_done(cycles, ok);
        tests++;
        if (!ok || bus.result !== 16'h0000 || bus.sreg !== 4'b0101) begin
            fails++;
            $display("FAIL sub_equal: result %h sreg %b want 0000 0101", bus.result, bus.sreg);
        end
        tick();
        send(OpSub, 16'h8000, 16'h0001);
        wait_done(cycles, ok);
        tests++;
        if (!ok || bus.result !== 16'h7FFF || bus.sreg !== 4'b1100) begin
            fails++;
            $display("FAIL sub_ovf: result %h sreg %b want 7fff 1100", bus.result, bus.sreg);
        end
        tick();
        send(OpSub, 16'h0003, 16'h0005);
        wait_done(cycles, ok);
        tests++;
        if (!ok || bus.result !== 16'hFFFE || bus.sreg !== 4'b0010) begin
            fails++;
            $display("FAIL sub_borrow: result %h sreg %b want fffe 0010", bus.result, bus.sreg);
        end
        tick();
    endtask

    task automatic test_illegal();
        int cycles;
        bit ok;
        send(3'b011, 16'h1234, 16'h5678);
        wait_done(cycles, ok);
        tests++;
        if (!ok || cycles != 1 || bus.err !== 1'b1 || bus.result !== 16'h0000 ||
            bus.sreg !== 4'b0010 || bus.result_hi !== 16'h0000) begin
            fails++;
            $display("FAIL illegal_011: err %b result %h sreg %b hi %h want 1 0000 0010 0000",
                     bus.err, bus.result, bus.sreg, bus.result_hi);
        end
        tick();
        tests++;
        if (bus.err !== 1'b1) begin
            fails++;
            $display("FAIL illegal_hold: err got %b want 1", bus.err);
        end
`ifndef ALU_SEQ_MUL_EN
        send(OpMul, 16'hFFFF, 16'hFFFF);
        wait_done(cycles, ok);
        tests++;
        if (!ok || cycles != 1 || bus.err !== 1'b1 || bus.result !== 16'h0000 ||
            bus.sreg !== 4'b0010 || bus.result_hi !== 16'h0000) begin
            fails++;
            $display("FAIL illegal_111: err %b result %h sreg %b hi %h want 1 0000 0010 0000",
                     bus.err, bus.result, bus.sreg, bus.result_hi);
        end
        tick();
`endif
        send(OpAdd, 16'h0001, 16'h0001);
        wait_done(cycles, ok);
        tests++;
        if (!ok || bus.err !== 1'b0 || bus.result !== 16'h0002 || bus.sreg !== 4'b0000) begin
            fails++;
            $display("FAIL err_clear: err %b result %h sreg %b want 0 0002 0000",
                     bus.err, bus.result, bus.sreg);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cycles;
        bit ok;
        send(OpAdd, 16'h0010, 16'h0020);
        wait_done(cycles, ok);
        bus.start = 1'b1;
        bus.op    = OpOr;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        tick();
        bus.start = 1'b0;
        tick();
        tests++;
        if (!ok || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'h0030) begin
            fails++;
            $display("FAIL done_cycle_start: busy %b done %b result %h want 0 0 0030",
                     bus.busy, bus.done, bus.result);
        end
        send(OpSub, 16'h0030, 16'h0010);
        wait_done(cycles, ok);
        tests++;
        if (!ok || cycles != 1 || bus.result !== 16'h0020 || bus.sreg !== 4'b0100) begin
            fails++;
            $display("FAIL back_to_back: result %h sreg %b want 0020 0100", bus.result, bus.sreg);
        end
        tick();
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic test_mul();
        int cycles;
        bit ok;
        send(OpMul, 16'h0003, 16'h0005);
        wait_done(cycles, ok);
        tests++;
        if (!ok || cycles != 16 || bus.result !== 16'h000F || bus.result_hi !== 16'h0000 ||
            bus.sreg !== 4'b0000) begin
            fails++;
            $display("FAIL mul_small: cycles %0d result %h hi %h sreg %b want 16 000f 0000 0000",
                     cycles, bus.result, bus.result_hi, bus.sreg);
        end
        tick();
        send(OpMul, 16'h1234, 16'h0100);
        wait_done(cycles, ok);
        tests++;
        if (!ok || bus.result !== 16'h3400 || bus.result_hi !== 16'h0012 ||
            bus.sreg !== 4'b1000) begin
            fails++;
            $display("FAIL mul_mid: result %h hi %h sreg %b want 3400 0012 1000",
                     bus.result, bus.result_hi, bus.sreg);
        end
        tick();
        send(OpMul, 16'h0000, 16'hBEEF);
        wait_done(cycles, ok);
        tests++;
        if (!ok || bus.result !== 16'h0000 || bus.result_hi !== 16'h0000 ||
            bus.sreg !== 4'b0001) begin
            fails++;
            $display("FAIL mul_zero: result %h hi %h sreg %b want 0000 0000 0001",
                     bus.result, bus.result_hi, bus.sreg);
        end
        tick();
    endtask

    task automatic test_mul_ignore();
        int busy_bad;
        int done_cnt;
        int done_at;
        busy_bad = 0;
        done_cnt = 0;
        done_at  = 0;
        send(OpMul, 16'hFFFF, 16'hFFFF);
        for (int i = 1; i <= 18; i++) begin
            bus.start = (i == 3 || i == 15);
            bus.op    = OpAdd;
            bus.a     = 16'h0001;
            bus.b     = 16'h0002;
            tick();
            if (bus.busy !== (i <= 16)) busy_bad++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
        end
        bus.start = 1'b0;
        tests++;
        if (busy_bad != 0) begin
            fails++;
            $display("FAIL mul_busy: %0d cycles with wrong busy, want 0", busy_bad);
        end
        tests++;
        if (done_cnt != 1 || done_at != 16) begin
            fails++;
            $display("FAIL mul_done: %0d pulses, last after edge k+%0d, want 1 at k+16",
                     done_cnt, done_at);
        end
        tests++;
        if (bus.result !== 16'h0001 || bus.result_hi !== 16'hFFFE || bus.sreg !== 4'b1010 ||
            bus.err !== 1'b0) begin
            fails++;
            $display("FAIL mul_ffff: result %h hi %h sreg %b err %b want 0001 fffe 1010 0",
                     bus.result, bus.result_hi, bus.sreg, bus.err);
        end
    endtask
`endif

    task automatic test_reset_mid_op();
        int cycles;
        bit ok;
        int done_seen;
        done_seen = 0;
`ifdef ALU_SEQ_MUL_EN
        send(OpMul, 16'h1234, 16'h0100);
        for (int i = 1; i <= 7; i++) tick();
`else
        send(OpAdd, 16'h1234, 16'h0100);
`endif
        rst_n = 1'b0;
        tick();
        tests++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000 ||
            {bus.result, bus.result_hi, bus.sreg} !== 36'h0) begin
            fails++;
            $display("FAIL reset_mid: busy %b done %b err %b result %h hi %h sreg %b want all 0",
                     bus.busy, bus.done, bus.err, bus.result, bus.result_hi, bus.sreg);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        tests++;
        if (done_seen != 0) begin
            fails++;
            $display("FAIL reset_abort: %0d cycles with busy/done after reset, want 0", done_seen);
        end
        send(OpAdd, 16'h0001, 16'h0002);
        wait_done(cycles, ok);
        tests++;
        if (!ok || bus.result !== 16'h0003 || bus.sreg !== 4'b0000 || bus.err !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_add: result %h sreg %b err %b want 0003 0000 0",
                     bus.result, bus.sreg, bus.err);
        end
        tick();
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        test_reset();
        test_add();
        test_logic();
        test_sub();
        test_illegal();
        test_back_to_back();
`ifdef ALU_SEQ_MUL_EN
        test_mul();
        test_mul_ignore();
`endif
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
